// File: rtl/adaptive_threshold.sv
// Adaptive firing-threshold unit: fixed / trace / spike-adaptation / combined modes.
// Per-neuron adaptation words are cleared by an INIT sweep after reset and can be
// decayed by an on-demand sweep. Requests pass through a 2-stage pipeline.
// Optional macro THR_PROG_EN adds a programmable per-neuron base-threshold memory.
module adaptive_threshold #(
  parameter int unsigned NEURON_NO = 256,
  parameter int unsigned THR       = 409,
  parameter int unsigned TS_WID    = 12,
  parameter int unsigned T_FIX_WID = 16,
  parameter int unsigned ADP_WID   = 12,
  parameter int unsigned ADP_INC   = 32,
  parameter int unsigned DEC_SHIFT = 4,
  parameter int unsigned N_ADDR    = $clog2(NEURON_NO)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           mode_i,
  input  logic [T_FIX_WID-1:0] ts_efa_o_th_i,
  input  logic                 req_vld_i,
  input  logic [N_ADDR-1:0]    req_addr_i,
  input  logic                 spike_i,
  output logic                 req_rdy_o,
  output logic                 thr_vld_o,
  output logic [N_ADDR-1:0]    thr_addr_o,
  output logic [TS_WID-1:0]    thr_o,
  output logic                 sat_o,
  input  logic                 decay_start_i,
  output logic                 decay_busy_o,
  input  logic                 prog_we_i,
  input  logic [N_ADDR-1:0]    prog_addr_i,
  input  logic [TS_WID-1:0]    prog_data_i
);

  localparam int unsigned SumW = TS_WID + 2;
  localparam logic [TS_WID-1:0]  ThrMax  = {TS_WID{1'b1}};
  localparam logic [ADP_WID-1:0] AdpMax  = {ADP_WID{1'b1}};
  localparam logic [N_ADDR-1:0]  LastIdx = N_ADDR'(NEURON_NO - 1);

  typedef enum logic [1:0] {StInit, StIdle, StDecay} state_e;

  state_e              state_q;
  logic [N_ADDR-1:0]   idx_q;
  logic                req_rdy_q, decay_busy_q;

  logic [ADP_WID-1:0]  adp_mem [NEURON_NO];

  logic                s1_vld_q, s1_spike_q;
  logic [N_ADDR-1:0]   s1_addr_q;
  logic [1:0]          s1_mode_q;
  logic [TS_WID-1:0]   s1_tr_q;
  logic [ADP_WID-1:0]  s1_adp_q;
  logic [TS_WID-1:0]   s1_base;

  logic                thr_vld_q, sat_q;
  logic [N_ADDR-1:0]   thr_addr_q;
  logic [TS_WID-1:0]   thr_q;

  logic                req_acc, s2_we, dec_en, thr_sat;
  logic [ADP_WID:0]    adp_inc_sum;
  logic [ADP_WID-1:0]  s2_wdata, adp_rd, dec_src, dec_sh, dec_val;
  logic [SumW-1:0]     thr_sum;
  logic [TS_WID-1:0]   thr_d, tr;

  logic unused_ts;
  assign unused_ts = ^ts_efa_o_th_i[T_FIX_WID-TS_WID-1:0];

  // Request acceptance, stage-2 arithmetic, read forwarding and decay step
  always_comb begin
    req_acc     = req_vld_i & req_rdy_q;
    tr          = ts_efa_o_th_i[T_FIX_WID-1 -: TS_WID];
    s2_we       = s1_vld_q & s1_spike_q;
    adp_inc_sum = {1'b0, s1_adp_q} + (ADP_WID+1)'(ADP_INC);
    s2_wdata    = (adp_inc_sum > {1'b0, AdpMax}) ? AdpMax : adp_inc_sum[ADP_WID-1:0];
    thr_sum     = SumW'(s1_base)
                + (s1_mode_q[0] ? SumW'(s1_tr_q)  : '0)
                + (s1_mode_q[1] ? SumW'(s1_adp_q) : '0);
    thr_sat     = thr_sum > SumW'(ThrMax);
    thr_d       = thr_sat ? ThrMax : thr_sum[TS_WID-1:0];
    // Stage-2 spike write lands this cycle; stage 1 must see it
    adp_rd      = (s2_we && (s1_addr_q == req_addr_i)) ? s2_wdata : adp_mem[req_addr_i];
    // Sweep only runs on cycles without a request
    dec_en      = (state_q == StDecay) & ~req_vld_i;
    dec_src     = (s2_we && (s1_addr_q == idx_q)) ? s2_wdata : adp_mem[idx_q];
    dec_sh      = dec_src >> DEC_SHIFT;
    dec_val     = ((dec_sh == '0) && (dec_src != '0)) ? dec_src - ADP_WID'(1)
                                                        : dec_src - dec_sh;
  end

  // Adaptation memory: INIT clears, spike write then decay write (decay already folds spike in)
  always_ff @(posedge clk_i) begin
    if (state_q == StInit) begin
      adp_mem[idx_q] <= '0;
    end else begin
      if (s2_we)  adp_mem[s1_addr_q] <= s2_wdata;
      if (dec_en) adp_mem[idx_q]     <= dec_val;
    end
  end

`ifdef THR_PROG_EN
  logic [TS_WID-1:0] base_mem [NEURON_NO];
  logic [TS_WID-1:0] s1_base_q, base_rd;
  logic              prog_ok;

  // Base-threshold read with same-cycle program forwarding
  always_comb begin
    prog_ok = prog_we_i & (state_q != StInit);
    base_rd = (prog_ok && (prog_addr_i == req_addr_i)) ? prog_data_i : base_mem[req_addr_i];
  end

  // Base memory: INIT loads the default threshold, then programmable
  always_ff @(posedge clk_i) begin
    if (state_q == StInit) base_mem[idx_q] <= TS_WID'(THR);
    else if (prog_ok)      base_mem[prog_addr_i] <= prog_data_i;
  end

  // Stage-1 base register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      s1_base_q <= TS_WID'(THR);
    else if (req_acc) s1_base_q <= base_rd;
  end

  assign s1_base = s1_base_q;
`else
  logic unused_prog;
  assign unused_prog = ^{prog_we_i, prog_addr_i, prog_data_i};
  assign s1_base     = TS_WID'(THR);
`endif

  // Control FSM: INIT clear sweep, IDLE, DECAY sweep stalled by requests
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StInit;
      idx_q        <= '0;
      req_rdy_q    <= 1'b0;
      decay_busy_q <= 1'b1;
    end else begin
      case (state_q)
        StInit: begin
          if (idx_q == LastIdx) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            req_rdy_q    <= 1'b1;
            decay_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + N_ADDR'(1);
          end
        end
        StIdle: begin
          if (decay_start_i) begin
            state_q      <= StDecay;
            idx_q        <= '0;
            decay_busy_q <= 1'b1;
          end
        end
        StDecay: begin
          if (dec_en) begin
            if (idx_q == LastIdx) begin
              state_q      <= StIdle;
              idx_q        <= '0;
              decay_busy_q <= 1'b0;
            end else begin
              idx_q <= idx_q + N_ADDR'(1);
            end
          end
        end
        default: begin
          state_q      <= StInit;
          idx_q        <= '0;
          req_rdy_q    <= 1'b0;
          decay_busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Request pipeline: stage 1 captures operands, stage 2 registers the result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q   <= 1'b0;
      s1_spike_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_mode_q  <= '0;
      s1_tr_q    <= '0;
      s1_adp_q   <= '0;
      thr_vld_q  <= 1'b0;
      thr_addr_q <= '0;
      thr_q      <= TS_WID'(THR);
      sat_q      <= 1'b0;
    end else begin
      s1_vld_q  <= req_acc;
      thr_vld_q <= s1_vld_q;
      if (req_acc) begin
        s1_spike_q <= spike_i;
        s1_addr_q  <= req_addr_i;
        s1_mode_q  <= mode_i;
        s1_tr_q    <= tr;
        s1_adp_q   <= adp_rd;
      end
      if (s1_vld_q) begin
        thr_q      <= thr_d;
        sat_q      <= thr_sat;
        thr_addr_q <= s1_addr_q;
      end
    end
  end

  assign req_rdy_o    = req_rdy_q;
  assign decay_busy_o = decay_busy_q;
  assign thr_vld_o    = thr_vld_q;
  assign thr_addr_o   = thr_addr_q;
  assign thr_o        = thr_q;
  assign sat_o        = sat_q;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Directed bench for adaptive_threshold; expected values are hand-computed.
module tb_adaptive_threshold;

`ifdef THR_PROG_EN
  localparam int ProgExp3 = 1000;
  localparam int ProgExp6 = 777;
`else
  localparam int ProgExp3 = 409;
  localparam int ProgExp6 = 409;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] ts;
  logic        req_vld, spike, decay_start, prog_we;
  logic [7:0]  req_addr, prog_addr, thr_addr;
  logic [11:0] prog_data, thr;
  logic        req_rdy, thr_vld, sat, decay_busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  adaptive_threshold dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mode_i        (mode),
    .ts_efa_o_th_i (ts),
    .req_vld_i     (req_vld),
    .req_addr_i    (req_addr),
    .spike_i       (spike),
    .req_rdy_o     (req_rdy),
    .thr_vld_o     (thr_vld),
    .thr_addr_o    (thr_addr),
    .thr_o         (thr),
    .sat_o         (sat),
    .decay_start_i (decay_start),
    .decay_busy_o  (decay_busy),
    .prog_we_i     (prog_we),
    .prog_addr_i   (prog_addr),
    .prog_data_i   (prog_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] a, input logic sp,
                       input logic [15:0] t);
    req_vld  = 1'b1;
    mode     = m;
    req_addr = a;
    spike    = sp;
    ts       = t;
  endtask

  task automatic idle_req();
    req_vld = 1'b0;
    spike   = 1'b0;
  endtask

  task automatic check_res(input string tag, input int exp_thr, input int exp_addr,
                           input logic exp_sat);
    check_eq({tag, ".vld"}, 32'(thr_vld), 32'd1);
    check_eq({tag, ".thr"}, 32'(thr), exp_thr);
    check_eq({tag, ".addr"}, 32'(thr_addr), exp_addr);
    check_eq({tag, ".sat"}, 32'(sat), 32'(exp_sat));
  endtask

  // One isolated request: no result after 1 cycle, result after 2
  task automatic single(input string tag, input logic [1:0] m, input logic [7:0] a,
                        input logic sp, input logic [15:0] t, input int exp_thr,
                        input logic exp_sat);
    drive(m, a, sp, t);
    step();
    idle_req();
    check_eq({tag, ".lat"}, 32'(thr_vld), 32'd0);
    step();
    check_res(tag, exp_thr, 32'(a), exp_sat);
  endtask

  // Count cycles from reset release to req_rdy; requests in the first cycle must be dropped
  task automatic wait_init(input string tag);
    int   cycles;
    logic seen_vld;
    cycles   = 0;
    seen_vld = 1'b0;
    drive(2'd0, 8'd1, 1'b0, 16'h0);
    do begin
      step();
      cycles++;
      idle_req();
      seen_vld |= thr_vld;
    end while (!req_rdy && cycles < 1000);
    check_eq({tag, ".rdy"}, 32'(req_rdy), 32'd1);
    check_eq({tag, ".cycles"}, cycles, 32'd256);
    check_eq({tag, ".dropped"}, 32'(seen_vld), 32'd0);
    check_eq({tag, ".busy"}, 32'(decay_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; mode = '0; ts = '0; req_vld = 1'b0; req_addr = '0; spike = 1'b0;
    decay_start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst.vld",  32'(thr_vld), 32'd0);
    check_eq("rst.thr",  32'(thr), 32'd409);
    check_eq("rst.sat",  32'(sat), 32'd0);
    check_eq("rst.rdy",  32'(req_rdy), 32'd0);
    check_eq("rst.busy", 32'(decay_busy), 32'd1);
    rst_n = 1'b1;
    wait_init("init");

    single("fix",   2'd0, 8'd5, 1'b0, 16'h0000, 409, 1'b0);
    single("trace", 2'd1, 8'd5, 1'b0, 16'h0A30, 572, 1'b0);

    // Back-to-back spikes on neuron 7 exercise write-back forwarding
    drive(2'd2, 8'd7, 1'b1, 16'h0); step();
    drive(2'd2, 8'd7, 1'b1, 16'h0); step(); check_res("b2b0", 409, 7, 1'b0);
    drive(2'd2, 8'd7, 1'b1, 16'h0); step(); check_res("b2b1", 441, 7, 1'b0);
    drive(2'd2, 8'd7, 1'b0, 16'h0); step(); check_res("b2b2", 473, 7, 1'b0);
    idle_req();                     step(); check_res("b2b3", 505, 7, 1'b0);

    single("spk7",  2'd2, 8'd7,  1'b1, 16'h0000, 505, 1'b0);   // adp[7] -> 128
    single("spk10", 2'd2, 8'd10, 1'b1, 16'h0000, 409, 1'b0);   // adp[10] -> 32
    single("m3sat", 2'd3, 8'd10, 1'b0, 16'hFFFF, 4095, 1'b1);

    // Decay sweep with three mid-sweep requests
    decay_start = 1'b1; step(); decay_start = 1'b0;
    check_eq("dec.busy", 32'(decay_busy), 32'd1);
    n = 0;
    while (decay_busy && n < 2000) begin
      case (n)
        20:      drive(2'd2, 8'd7,   1'b0, 16'h0);
        21:      drive(2'd0, 8'd200, 1'b0, 16'h0);
        22:      drive(2'd2, 8'd200, 1'b0, 16'h0);
        default: idle_req();
      endcase
      step();
      n++;
      if (n == 22) check_res("mid0", 529, 7, 1'b0);
      if (n == 23) check_res("mid1", 409, 200, 1'b0);
      if (n == 24) check_res("mid2", 409, 200, 1'b0);
    end
    check_eq("dec.cycles", n, 32'd259);
    single("adp7",  2'd2, 8'd7,  1'b0, 16'h0, 529, 1'b0);
    single("adp10", 2'd2, 8'd10, 1'b0, 16'h0, 439, 1'b0);
    single("adp5",  2'd2, 8'd5,  1'b0, 16'h0, 409, 1'b0);

    // 130 spikes would overflow 12 bits; adp must clamp at 4095
    for (int i = 0; i < 130; i++) begin
      drive(2'd0, 8'd20, 1'b1, 16'h0);
      step();
    end
    idle_req(); step(); step();
    single("adpsat", 2'd2, 8'd20, 1'b0, 16'h0, 4095, 1'b1);

    // Reset at sweep index 100 with a request in flight
    decay_start = 1'b1; step(); decay_start = 1'b0;
    repeat (100) step();
    drive(2'd2, 8'd7, 1'b1, 16'h0);
    step();
    idle_req();
    #1 rst_n = 1'b0;
    #1;
    check_eq("mrst.vld",  32'(thr_vld), 32'd0);
    check_eq("mrst.thr",  32'(thr), 32'd409);
    check_eq("mrst.addr", 32'(thr_addr), 32'd0);
    check_eq("mrst.sat",  32'(sat), 32'd0);
    check_eq("mrst.rdy",  32'(req_rdy), 32'd0);
    check_eq("mrst.busy", 32'(decay_busy), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit");
    single("post7",  2'd2, 8'd7,  1'b0, 16'h0, 409, 1'b0);
    single("post20", 2'd2, 8'd20, 1'b0, 16'h0, 409, 1'b0);

    // Base-threshold programming (ignored unless THR_PROG_EN)
    prog_we = 1'b1; prog_addr = 8'd3; prog_data = 12'd1000;
    step();
    prog_we = 1'b0;
    single("prog3", 2'd0, 8'd3, 1'b0, 16'h0, ProgExp3, 1'b0);
    single("prog4", 2'd0, 8'd4, 1'b0, 16'h0, 409, 1'b0);
    prog_we = 1'b1; prog_addr = 8'd6; prog_data = 12'd777;
    drive(2'd0, 8'd6, 1'b0, 16'h0);
    step();
    prog_we = 1'b0;
    idle_req();
    step();
    check_res("progfwd", ProgExp6, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
